// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//   Control unit for a multicycle MIPS-style datapath. A 12-state Moore FSM
//   steps each instruction through fetch, decode, execute, memory and
//   writeback. The only Mealy-style term is pcen, which folds in the ALU zero
//   flag so that a taken beq updates the PC in BEQEX without an extra cycle.
//
// Ports
//   clk        in   1  sole clock, rising edge
//   reset      in   1  synchronous active-high reset
//   op         in   6  opcode field instr[31:26]
//   funct      in   6  function field instr[5:0] (R-type only)
//   zero       in   1  ALU zero flag
//   pcen       out  1  PC register enable
//   irwrite    out  1  instruction register enable
//   memwrite   out  1  data memory write enable
//   regwrite   out  1  register file write enable
//   iord       out  1  memory address select (0 PC, 1 ALUOut)
//   memtoreg   out  1  writeback select (0 ALUOut, 1 memory data)
//   regdst     out  1  destination register select (0 rt, 1 rd)
//   alusrca    out  1  ALU A select (0 PC, 1 register A)
//   alusrcb    out  2  ALU B select (00 B, 01 4, 10 imm, 11 imm<<2)
//   pcsrc      out  2  next-PC select (00 ALU, 01 ALUOut, 10 jump)
//   alucontrol out  3  ALU function
//   state      out  4  current FSM state
// -----------------------------------------------------------------------------
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  state_t state_r;
  state_t next_s;

  logic pcwrite_s;
  logic branch_s;
  logic irwrite_s;
  logic memwrite_s;
  logic regwrite_s;

  // R-type ALU decode; unknown funct codes drive the ALU to output 0.
  function automatic logic [2:0] funct_to_alu(input logic [5:0] f);
    logic [2:0] a;
    case (f)
      6'b100000: a = 3'b010;
      6'b100010: a = 3'b110;
      6'b100100: a = 3'b001;
      6'b100101: a = 3'b011;
      6'b101010: a = 3'b111;
      default:   a = 3'b000;
    endcase
    return a;
  endfunction

  assign state = state_r;

  // State register with synchronous reset back to FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= FETCH;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic; op is only consulted in DECODE and MEMADR.
  always_comb begin
    next_s = FETCH;
    case (state_r)
      FETCH: next_s = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: next_s = MEMADR;
          OP_RTYPE:     next_s = RTYPEEX;
          OP_BEQ:       next_s = BEQEX;
          OP_ADDI:      next_s = ADDIEX;
          OP_J:         next_s = JEX;
          default:      next_s = FETCH;
        endcase
      end
      MEMADR: begin
        if (op == OP_SW) begin
          next_s = MEMWR;
        end else begin
          next_s = MEMRD;
        end
      end
      MEMRD:   next_s = MEMWB;
      RTYPEEX: next_s = RTYPEWB;
      ADDIEX:  next_s = ADDIWB;
      // MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX and unused codes 12-15.
      default: next_s = FETCH;
    endcase
  end

  // Moore output decode; every control defaults to 0 and the ALU to add.
  always_comb begin
    pcwrite_s  = 1'b0;
    branch_s   = 1'b0;
    irwrite_s  = 1'b0;
    memwrite_s = 1'b0;
    regwrite_s = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = 3'b010;
    case (state_r)
      FETCH: begin
        alusrcb   = 2'b01;
        irwrite_s = 1'b1;
        pcwrite_s = 1'b1;
      end
      DECODE: begin
        // Branch target is precomputed here while the opcode is decoded.
        alusrcb = 2'b11;
      end
      MEMADR, ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: begin
        iord = 1'b1;
      end
      MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_s = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        memwrite_s = 1'b1;
      end
      RTYPEEX: begin
        alusrca    = 1'b1;
        alucontrol = funct_to_alu(funct);
      end
      RTYPEWB: begin
        regdst     = 1'b1;
        regwrite_s = 1'b1;
      end
      BEQEX: begin
        alusrca    = 1'b1;
        alucontrol = 3'b110;
        pcsrc      = 2'b01;
        branch_s   = 1'b1;
      end
      ADDIWB: begin
        regwrite_s = 1'b1;
      end
      JEX: begin
        pcsrc     = 2'b10;
        pcwrite_s = 1'b1;
      end
      default: begin
        alucontrol = 3'b010;
      end
    endcase
  end

  // Write enables are suppressed for the whole time reset is held.
  always_comb begin
    if (reset) begin
      pcen     = 1'b0;
      irwrite  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
    end else begin
      pcen     = pcwrite_s | (branch_s & zero);
      irwrite  = irwrite_s;
      memwrite = memwrite_s;
      regwrite = regwrite_s;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//   Directed bench for multicycle_controller. Each instruction is expanded
//   into its expected state path; every cycle pushes the expected output
//   vector onto a queue that a negedge compare process checks. Literal checks
//   pin key cycles independently of the model.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen;
  logic       irwrite;
  logic       memwrite;
  logic       regwrite;
  logic       iord;
  logic       memtoreg;
  logic       regdst;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  typedef struct packed {
    logic [3:0] st;
    logic       pcen;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alu;
  } obs_t;

  obs_t obs_s;
  obs_t exp_q[$];
  int   n_cmp;
  int   n_bad;

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .pcen       (pcen),
    .irwrite    (irwrite),
    .memwrite   (memwrite),
    .regwrite   (regwrite),
    .iord       (iord),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .state      (state)
  );

  assign obs_s = '{st: state, pcen: pcen, irwrite: irwrite, memwrite: memwrite,
                   regwrite: regwrite, iord: iord, memtoreg: memtoreg,
                   regdst: regdst, alusrca: alusrca, alusrcb: alusrcb,
                   pcsrc: pcsrc, alu: alucontrol};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs for a given state, as the control table describes them.
  function automatic obs_t model_outs(input int st, input logic [5:0] fn,
                                      input logic z, input logic rst);
    obs_t o;
    o = '0;
    o.st = st[3:0];
    o.alu = 3'b010;
    case (st)
      0:  begin o.alusrcb = 2'b01; o.irwrite = 1'b1; o.pcen = 1'b1; end
      1:  o.alusrcb = 2'b11;
      2, 9: begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
      3:  o.iord = 1'b1;
      4:  begin o.memtoreg = 1'b1; o.regwrite = 1'b1; end
      5:  begin o.iord = 1'b1; o.memwrite = 1'b1; end
      6:  begin
        o.alusrca = 1'b1;
        case (fn)
          6'd32:   o.alu = 3'b010;
          6'd34:   o.alu = 3'b110;
          6'd36:   o.alu = 3'b001;
          6'd37:   o.alu = 3'b011;
          6'd42:   o.alu = 3'b111;
          default: o.alu = 3'b000;
        endcase
      end
      7:  begin o.regdst = 1'b1; o.regwrite = 1'b1; end
      8:  begin o.alusrca = 1'b1; o.alu = 3'b110; o.pcsrc = 2'b01; o.pcen = z; end
      10: o.regwrite = 1'b1;
      11: begin o.pcsrc = 2'b10; o.pcen = 1'b1; end
      default: o.alu = 3'b010;
    endcase
    if (rst) begin
      o.pcen = 1'b0;
      o.irwrite = 1'b0;
      o.memwrite = 1'b0;
      o.regwrite = 1'b0;
    end
    return o;
  endfunction

  // Per-cycle comparison of the full output vector against the model.
  always @(negedge clk) begin
    obs_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_s !== e) begin
        n_bad++;
        $display("FAIL cycle_vector t=%0t actual=%h required=%h", $time, obs_s, e);
      end
    end
  end

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, req);
    end
  endtask

  // Runs one instruction from FETCH; reset is raised at cycle rst_at (if >= 0).
  task automatic run_instr(input logic [5:0] iop, input logic [5:0] ifn,
                           input logic zb, input int rst_at);
    int   path[$];
    logic samp;
    logic uses_op2;
    case (iop)
      6'b100011: path = '{0, 1, 2, 3, 4};
      6'b101011: path = '{0, 1, 2, 5};
      6'b000000: path = '{0, 1, 6, 7};
      6'b000100: path = '{0, 1, 8};
      6'b001000: path = '{0, 1, 9, 10};
      6'b000010: path = '{0, 1, 11};
      default:   path = '{0, 1};
    endcase
    uses_op2 = (iop == 6'b100011) || (iop == 6'b101011) || (iop == 6'b000000);
    for (int i = 0; i < path.size(); i++) begin
      samp  = (i == 1) || ((i == 2) && uses_op2);
      op    = samp ? iop : ~iop;
      funct = (path[i] == 6) ? ifn : ~ifn;
      zero  = (path[i] == 8) ? zb : 1'b1;
      reset = (i == rst_at);
      exp_q.push_back(model_outs(path[i], funct, zero, reset));
      @(negedge clk);
      if (i == 0) begin
        check("fetch_state", 8'(state), 8'd0);
        check("fetch_irwrite", 8'(irwrite), 8'd1);
      end
      if (reset) begin
        check("rst_memwrite", 8'(memwrite), 8'd0);
        check("rst_pcen", 8'(pcen), 8'd0);
      end
      case (path[i])
        1:  check("decode_nowrite", 8'({memwrite, regwrite}), 8'd0);
        3:  check("memrd_iord", 8'(iord), 8'd1);
        4:  check("memwb_wr", 8'({regwrite, memtoreg}), 8'd3);
        5:  check("memwr_we", 8'(memwrite), reset ? 8'd0 : 8'd1);
        6:  if (ifn == 6'b101010) check("slt_alu", 8'(alucontrol), 8'd7);
        7:  check("rtwb_wr", 8'({regdst, regwrite}), 8'd3);
        8:  begin
          check("beq_pcen", 8'(pcen), zb ? 8'd1 : 8'd0);
          check("beq_pcsrc", 8'(pcsrc), 8'd1);
          check("beq_alu", 8'(alucontrol), 8'd6);
        end
        11: check("j_pcsrc_pcen", 8'({pcsrc, pcen}), 8'd5);
        default: check("other_pcen", 8'(pcen), (path[i] == 0) ? 8'd1 : 8'd0);
      endcase
      @(posedge clk);
      #1;
      if (reset) break;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    op    = 6'b000000;
    funct = 6'b000000;
    zero  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Held in reset: FETCH decode visible, write enables forced low.
    exp_q.push_back(model_outs(0, funct, zero, 1'b1));
    @(negedge clk);
    check("reset_state", 8'(state), 8'd0);
    check("reset_irwrite", 8'(irwrite), 8'd0);
    @(posedge clk);
    #1;

    run_instr(6'b100011, 6'b000000, 1'b0, -1);  // lw
    run_instr(6'b000000, 6'b101010, 1'b0, -1);  // slt
    run_instr(6'b000000, 6'b100000, 1'b0, -1);  // add
    run_instr(6'b000000, 6'b100010, 1'b0, -1);  // sub
    run_instr(6'b000000, 6'b100100, 1'b0, -1);  // and
    run_instr(6'b000000, 6'b100101, 1'b0, -1);  // or
    run_instr(6'b000000, 6'b111000, 1'b0, -1);  // unknown funct
    run_instr(6'b000100, 6'b000000, 1'b1, -1);  // beq taken
    run_instr(6'b000100, 6'b000000, 1'b0, -1);  // beq not taken
    run_instr(6'b001000, 6'b000000, 1'b0, -1);  // addi
    run_instr(6'b111111, 6'b000000, 1'b0, -1);  // illegal
    run_instr(6'b101011, 6'b000000, 1'b0, -1);  // sw
    run_instr(6'b000010, 6'b000000, 1'b0, -1);  // j
    run_instr(6'b101011, 6'b000000, 1'b0, 3);   // sw, reset in MEMWR
    run_instr(6'b100011, 6'b000000, 1'b0, 2);   // lw, reset in MEMADR
    run_instr(6'b001000, 6'b000000, 1'b0, -1);  // addi after reset

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 No parameters; all widths fixed.
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset; sampled on rising edge of clk.
REQ-004 op  in  6  opcode field, instr[31:26].
REQ-005 funct  in  6  function field, instr[5:0]; used only for R-type.
REQ-006 zero  in  1  ALU zero flag, 1 when ALU result == 0.
REQ-007 pcen  out  1  PC register enable.
REQ-008 irwrite  out  1  instruction register enable.
REQ-009 memwrite  out  1  data memory write enable.
REQ-010 regwrite  out  1  register file write enable.
REQ-011 iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-012 memtoreg  out  1  writeback select: 0 = ALUOut, 1 = memory data.
REQ-013 regdst  out  1  dest register select: 0 = rt, 1 = rd.
REQ-014 alusrca  out  1  ALU A select: 0 = PC, 1 = register A.
REQ-015 alusrcb  out  2  ALU B select: 00 = reg B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2.
REQ-016 pcsrc  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-017 alucontrol  out  3  ALU function: 010 add, 110 sub, 111 set-less-than, 001 and, 011 or, 000 ALU outputs 0.
REQ-018 state  out  4  current FSM state (debug/verification visibility).

Function
REQ-019 The block SHALL be a 12-state FSM with encodings FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11; encodings 12-15 SHALL go to FETCH on the next edge.
REQ-020 Transitions: FETCH->DECODE; DECODE->MEMADR if op is 100011 (lw) or 101011 (sw), RTYPEEX if 000000, BEQEX if 000100, ADDIEX if 001000, JEX if 000010; any other op->FETCH (illegal op, no side effects).
REQ-021 MEMADR->MEMRD for lw, MEMWR for sw; MEMRD->MEMWB; RTYPEEX->RTYPEWB; ADDIEX->ADDIWB; MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX->FETCH.
REQ-022 All outputs except pcen SHALL be combinational functions of state only (Moore); any output not listed for a state SHALL be 0, and alucontrol not listed SHALL be 010.
REQ-023 FETCH: iord=0, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00, irwrite=1, PC write asserted.
REQ-024 DECODE: alusrca=0, alusrcb=11, alucontrol=010 (branch target precompute).
REQ-025 MEMADR and ADDIEX: alusrca=1, alusrcb=10, alucontrol=010.
REQ-026 MEMRD: iord=1; MEMWR: iord=1, memwrite=1.
REQ-027 MEMWB: regdst=0, memtoreg=1, regwrite=1; ADDIWB: regdst=0, memtoreg=0, regwrite=1; RTYPEWB: regdst=1, memtoreg=0, regwrite=1.
REQ-028 RTYPEEX: alusrca=1, alusrcb=00, alucontrol from funct: 100000->010, 100010->110, 100100->001, 100101->011, 101010->111, any other->000.
REQ-029 BEQEX: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, branch asserted; JEX: pcsrc=10, PC write asserted.
REQ-030 pcen SHALL equal PC-write OR (branch AND zero), combinational, so a taken beq updates PC in BEQEX with no extra cycle.
REQ-031 Latency from FETCH entry to next FETCH entry: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2 cycles.
REQ-032 op and funct SHALL be sampled only in DECODE, MEMADR and RTYPEEX; changes in other states SHALL have no effect.
REQ-033 zero SHALL affect only pcen and only in BEQEX.

Reset
REQ-034 reset high at a rising edge SHALL load state=FETCH regardless of current state, including mid-instruction.
REQ-035 While reset is high, pcen, irwrite, memwrite and regwrite SHALL be forced to 0; all other outputs follow the current state.
REQ-036 After reset deasserts, the first rising edge SHALL perform a normal FETCH (irwrite=1, pcen=1).

Verification
REQ-037 Reset, then op=100011: state sequence 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4; iord=1 in state 3.
REQ-038 op=000000, funct=101010: states 0,1,6,7,0; alucontrol=111 in state 6; regdst=1, regwrite=1 in state 7.
REQ-039 op=000100, zero=1 in BEQEX: pcen=1, pcsrc=01, alucontrol=110; repeat with zero=0: pcen=0; zero=1 in any other non-FETCH/JEX state: pcen=0.
REQ-040 op=111111 (illegal): states 0,1,0; memwrite=regwrite=0 throughout.
REQ-041 Assert reset during MEMWR (state 5): memwrite=0 while reset high; state=0 after the edge; first post-reset cycle shows irwrite=1.
REQ-042 op=101011 then op=000010: sw states 0,1,2,5,0 with memwrite=1 only in 5; j states 0,1,11,0 with pcsrc=10, pcen=1 in 11.
